// File: rtl/ysyx_220053_fetch_unit_pkg.sv
// ysyx_220053_ifu_pkg: shared types for the ysyx_220053 instruction fetch unit.
//   ifu_state_e : fetch FSM states (IDLE, REQ, WAIT)
//   fq_entry_t  : default fetch-queue entry {pc, instr, err}
//   sel_instr() : picks the 32-bit instruction out of a 64-bit memory beat
package ysyx_220053_ifu_pkg;

  localparam int INSTR_W  = 32;
  localparam int IFU_XLEN = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } ifu_state_e;

  typedef struct packed {
    logic [IFU_XLEN-1:0] pc;
    logic [INSTR_W-1:0]  instr;
    logic                err;
  } fq_entry_t;

  // Upper word holds the instruction at pc[2]==1, lower word at pc[2]==0.
  function automatic logic [INSTR_W-1:0] sel_instr(input logic [63:0] data,
                                                   input logic        hi);
    return hi ? data[63:32] : data[31:0];
  endfunction

endpackage

// File: rtl/ysyx_220053_fetch_unit_if.sv
// ysyx_220053_fetch_unit_if: memory read channel of the fetch unit.
//   req_valid/req_ready/req_addr : read request handshake (64-bit aligned)
//   rsp_valid/rsp_data/rsp_err   : read response, at most one per request
//   master modport: fetch unit side; slave modport: memory side.
interface ysyx_220053_fetch_unit_if #(
  parameter int XLEN  = 64,
  parameter int MEM_W = 64
);
  logic             req_valid;
  logic             req_ready;
  logic [XLEN-1:0]  req_addr;
  logic             rsp_valid;
  logic [MEM_W-1:0] rsp_data;
  logic             rsp_err;

  modport master (
    output req_valid, req_addr,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/ysyx_220053_fetch_fifo.sv
// ysyx_220053_fetch_fifo: synchronous FIFO holding fetched instructions.
//   clk, rst   : clock, synchronous active-high reset (pointers/count only)
//   push/push_data : write an entry at the tail
//   pop        : remove the head entry
//   flush      : empty the queue; has priority over push and pop
//   count      : number of valid entries (0..DEPTH)
//   head       : oldest entry, valid when count != 0
// Push and pop in the same cycle are both honoured, including when full.
module ysyx_220053_fetch_fifo
  import ysyx_220053_ifu_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fq_entry_t,
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [CW-1:0] count,
  output entry_t        head
);

  entry_t        slots [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (flush) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      if (push) wr_d = wr_q + AW'(1);
      if (pop)  rd_d = rd_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  // Storage carries data only; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push && !flush) slots[wr_q] <= push_data;
  end

  assign count = count_q;
  assign head  = slots[rd_q];

endmodule

// File: rtl/ysyx_220053_fetch_unit.sv
// ysyx_220053_fetch_unit: instruction fetch unit of the ysyx_220053 core.
//   clk, rst       : clock, synchronous active-high reset
//   redirect_valid/redirect_pc : new fetch PC from execute; flushes the queue
//   mem (master)   : 64-bit aligned read request / response channel
//   out_valid/out_ready : decode handshake
//   out_pc/out_instr/out_err : head instruction, its PC and fault flag
// Optional build macro: IFU_BYPASS_EN -- when the queue is empty, a fresh
// response is presented to decode in the same cycle it arrives.
module ysyx_220053_fetch_unit
  import ysyx_220053_ifu_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000),
  parameter int              FQ_DEPTH = 4,
  parameter int              MEM_W    = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    redirect_valid,
  input  logic [XLEN-1:0]         redirect_pc,
  ysyx_220053_fetch_unit_if.master mem,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_pc,
  output logic [INSTR_W-1:0]      out_instr,
  output logic                    out_err
);

  localparam int CW = $clog2(FQ_DEPTH) + 1;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic               err;
  } entry_t;

  ifu_state_e      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            drop_q, drop_d;

  logic [CW-1:0]   fq_count;
  entry_t          fq_head, rsp_entry, out_entry;
  logic            q_nonempty, rsp_take, bypass, push, pop;

  // A response is kept only if nothing has redirected fetch since issue.
  // While drop_q is clear, pc_q is still the PC the request was issued for.
  always_comb begin
    rsp_take        = (state_q == WAIT) && mem.rsp_valid && !drop_q && !redirect_valid;
    rsp_entry.pc    = pc_q;
    rsp_entry.instr = sel_instr(mem.rsp_data, pc_q[2]);
    rsp_entry.err   = mem.rsp_err;
  end

  assign q_nonempty = (fq_count != '0);

`ifdef IFU_BYPASS_EN
  assign bypass = rsp_take && !q_nonempty;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed entry accepted by decode never enters the queue.
  assign push = rsp_take && !(bypass && out_ready);
  // The flush wins over a coincident pop.
  assign pop  = q_nonempty && out_ready && !redirect_valid;

  ysyx_220053_fetch_fifo #(
    .DEPTH   (FQ_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (rsp_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (fq_count),
    .head      (fq_head)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    drop_d  = drop_q;

    // The queue slot is reserved here: with one request outstanding and
    // only pops in between, the later push always finds room.
    unique case (state_q)
      IDLE: if (fq_count < CW'(FQ_DEPTH)) state_d = REQ;
      REQ:  if (mem.req_ready)            state_d = WAIT;
      WAIT: if (mem.rsp_valid) begin
        state_d = IDLE;
        drop_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    if (rsp_take) pc_d = pc_q + XLEN'(4);

    // A request already on the bus is completed and its response discarded,
    // unless that response is arriving right now.
    if (redirect_valid) begin
      pc_d = redirect_pc & ~XLEN'(3);
      if (state_q == REQ || (state_q == WAIT && !mem.rsp_valid)) drop_d = 1'b1;
    end

    // The address is latched at issue so it stays stable through REQ even
    // if a redirect moves pc_q.
    if (state_q == IDLE && state_d == REQ) addr_d = pc_d & ~XLEN'(7);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_d;
  end

  assign mem.req_valid = (state_q == REQ);
  assign mem.req_addr  = addr_q;

  // Head storage is not reset, so outputs are forced to zero while empty.
  always_comb begin
    out_entry = '0;
    if (q_nonempty)  out_entry = fq_head;
    else if (bypass) out_entry = rsp_entry;
  end

  assign out_valid = q_nonempty || bypass;
  assign out_pc    = out_entry.pc;
  assign out_instr = out_entry.instr;
  assign out_err   = out_entry.err;

endmodule
